// File: rtl/obi_pkg.sv
// rtl/obi_pkg.sv - shared OBI widths, response entry type and byte-lane merge helper
package obi_pkg;

    localparam int OBI_ADDR_W = 32;
    localparam int OBI_DATA_W = 32;
    localparam int OBI_BE_W   = 4;

    typedef enum logic {
        ST_IDLE,
        ST_WAIT
    } gnt_state_e;

    typedef struct packed {
        logic                  valid;
        logic                  we;
        logic [OBI_DATA_W-1:0] rdata;
    } obi_resp_t;

    function automatic logic [OBI_DATA_W-1:0] be_merge(
        input logic [OBI_DATA_W-1:0] old_word,
        input logic [OBI_DATA_W-1:0] new_word,
        input logic [OBI_BE_W-1:0]   be
    );
        logic [OBI_DATA_W-1:0] merged;
        merged = old_word;
        for (int i = 0; i < OBI_BE_W; i++) begin
            if (be[i]) merged[8*i +: 8] = new_word[8*i +: 8];
        end
        return merged;
    endfunction

endpackage

// File: rtl/obi_resp_pipe.sv
// rtl/obi_resp_pipe.sv - fixed-latency response shift register with synchronous clear
module obi_resp_pipe
    import obi_pkg::*;
#(
    parameter int DEPTH = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  obi_resp_t             push,
    output logic                  valid,
    output logic [OBI_DATA_W-1:0] rdata
);

    obi_resp_t stage [DEPTH];
    obi_resp_t tail;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
        end else begin
            stage[0] <= push;
            for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
        end
    end

    // Write responses and empty slots always present zero data.
    assign tail  = stage[DEPTH-1];
    assign valid = tail.valid;
    assign rdata = (tail.valid && !tail.we) ? tail.rdata : '0;

endmodule

// File: rtl/obi_sram.sv
// rtl/obi_sram.sv - OBI slave scratch RAM with programmable grant wait and response latency
module obi_sram
    import obi_pkg::*;
#(
    parameter int ADDR_WIDTH = 10,
    parameter int GNT_WAIT   = 0,
    parameter int RVALID_LAT = 1
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  req_i,
    output logic                  gnt_o,
    input  logic [OBI_ADDR_W-1:0] addr_i,
    input  logic                  we_i,
    input  logic [OBI_BE_W-1:0]   be_i,
    input  logic [OBI_DATA_W-1:0] wdata_i,
    output logic                  rvalid_o,
    output logic [OBI_DATA_W-1:0] rdata_o
);

    localparam int MEM_WORDS = 1 << ADDR_WIDTH;

    if (RVALID_LAT < 1 || RVALID_LAT > 8) begin : g_bad_lat
        $error("obi_sram: RVALID_LAT must be within 1..8");
    end
    if (ADDR_WIDTH > 30) begin : g_bad_aw
        $error("obi_sram: ADDR_WIDTH must not exceed 30");
    end

    logic [OBI_DATA_W-1:0] mem [MEM_WORDS];
    logic [ADDR_WIDTH-1:0] word_idx;
    logic                  accept;
    logic                  unused_addr;
    obi_resp_t             resp_in;

    // Byte offset and high bits are don't-care, so upper addresses alias.
    assign word_idx    = addr_i[ADDR_WIDTH+1:2];
    assign unused_addr = ^addr_i;
    assign accept      = req_i && gnt_o;

    if (GNT_WAIT == 0) begin : g_no_wait
        assign gnt_o = req_i && !rst_i;
    end else begin : g_wait
        localparam int CW = $clog2(GNT_WAIT + 1);

        gnt_state_e    state, state_next;
        logic [CW-1:0] cnt, cnt_next;
        logic          grant;

        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                state <= ST_IDLE;
                cnt   <= '0;
            end else begin
                state <= state_next;
                cnt   <= cnt_next;
            end
        end

        always_comb begin
            state_next = state;
            cnt_next   = cnt;
            grant      = req_i && !rst_i && (state == ST_WAIT) && (cnt == CW'(GNT_WAIT));
            case (state)
                ST_IDLE: begin
                    if (req_i) begin
                        state_next = ST_WAIT;
                        cnt_next   = CW'(1);
                    end
                end
                ST_WAIT: begin
                    if (!req_i || grant) begin
                        state_next = ST_IDLE;
                        cnt_next   = '0;
                    end else begin
                        cnt_next = cnt + CW'(1);
                    end
                end
                default: begin
                    state_next = ST_IDLE;
                    cnt_next   = '0;
                end
            endcase
        end

        assign gnt_o = grant;
    end

    always_ff @(posedge clk_i) begin
        if (accept && we_i) mem[word_idx] <= be_merge(mem[word_idx], wdata_i, be_i);
    end

    always_comb begin
        resp_in       = '0;
        resp_in.valid = accept;
        resp_in.we    = we_i;
        resp_in.rdata = we_i ? '0 : mem[word_idx];
    end

    obi_resp_pipe #(
        .DEPTH(RVALID_LAT)
    ) u_resp_pipe (
        .clk   (clk_i),
        .rst   (rst_i),
        .push  (resp_in),
        .valid (rvalid_o),
        .rdata (rdata_o)
    );

endmodule

// File: tb/tb_obi_sram.sv
// tb/tb_obi_sram.sv - directed self-checking bench for obi_sram over four parameter sets
`timescale 1ns/1ps
module tb_obi_sram;

    localparam int N = 4;

    typedef struct packed {
        int          inst;
        int          due;
        logic [31:0] data;
    } pend_t;

    typedef struct packed {
        int          inst;
        int          cyc;
        logic [31:0] data;
    } seen_t;

    logic               clk = 1'b0;
    logic               rst;
    logic [N-1:0]       req, we, gnt, rvalid;
    logic [N-1:0][31:0] addr, wdata, rdata;
    logic [N-1:0][3:0]  be;

    pend_t       pend [$];
    seen_t       seen [$];
    logic [31:0] model_mem [int];
    int          run [N];
    logic [N-1:0] last_gnt;
    int          cyc;
    int          checks;
    int          failures;

    always #5 clk = ~clk;

    obi_sram #(.ADDR_WIDTH(4), .GNT_WAIT(0), .RVALID_LAT(1)) u_basic (
        .clk_i(clk), .rst_i(rst), .req_i(req[0]), .gnt_o(gnt[0]), .addr_i(addr[0]), .we_i(we[0]),
        .be_i(be[0]), .wdata_i(wdata[0]), .rvalid_o(rvalid[0]), .rdata_o(rdata[0]));

    obi_sram #(.ADDR_WIDTH(10), .GNT_WAIT(3), .RVALID_LAT(1)) u_wait (
        .clk_i(clk), .rst_i(rst), .req_i(req[1]), .gnt_o(gnt[1]), .addr_i(addr[1]), .we_i(we[1]),
        .be_i(be[1]), .wdata_i(wdata[1]), .rvalid_o(rvalid[1]), .rdata_o(rdata[1]));

    obi_sram #(.ADDR_WIDTH(10), .GNT_WAIT(0), .RVALID_LAT(4)) u_pipe (
        .clk_i(clk), .rst_i(rst), .req_i(req[2]), .gnt_o(gnt[2]), .addr_i(addr[2]), .we_i(we[2]),
        .be_i(be[2]), .wdata_i(wdata[2]), .rvalid_o(rvalid[2]), .rdata_o(rdata[2]));

    obi_sram #(.ADDR_WIDTH(10), .GNT_WAIT(0), .RVALID_LAT(3)) u_rst (
        .clk_i(clk), .rst_i(rst), .req_i(req[3]), .gnt_o(gnt[3]), .addr_i(addr[3]), .we_i(we[3]),
        .be_i(be[3]), .wdata_i(wdata[3]), .rvalid_o(rvalid[3]), .rdata_o(rdata[3]));

    function automatic int cfg_aw(input int k);
        return (k == 0) ? 4 : 10;
    endfunction

    function automatic int cfg_gw(input int k);
        return (k == 1) ? 3 : 0;
    endfunction

    function automatic int cfg_lat(input int k);
        case (k)
            2:       return 4;
            3:       return 3;
            default: return 1;
        endcase
    endfunction

    task automatic chk(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s inst=%0d cyc=%0d actual=%08h expected=%08h", name, k, cyc, act, exp);
        end
    endtask

    // Reference: grant after GNT_WAIT prior held-request cycles, responses due LAT cycles after accept.
    task automatic model_step();
        for (int k = 0; k < N; k++) begin
            logic        eg;
            logic        ev;
            logic [31:0] ed;
            logic [31:0] w;
            int          qi;
            int          key;
            eg = !rst && req[k] && (cfg_gw(k) == 0 || run[k] == cfg_gw(k));
            qi = -1;
            for (int j = 0; j < pend.size(); j++) begin
                if (qi < 0 && pend[j].inst == k) qi = j;
            end
            ev = (qi >= 0) && (pend[qi].due == cyc);
            ed = ev ? pend[qi].data : 32'h0;
            chk("gnt", k, {31'h0, gnt[k]}, {31'h0, eg});
            chk("rvalid", k, {31'h0, rvalid[k]}, {31'h0, ev});
            chk("rdata", k, rdata[k], ed);
            last_gnt[k] = gnt[k];
            if (rvalid[k]) seen.push_back('{k, cyc, rdata[k]});
            if (ev) pend.delete(qi);
            if (rst) begin
                run[k] = 0;
            end else if (eg) begin
                key = k * 4096 + (int'(addr[k] >> 2) % (1 << cfg_aw(k)));
                w   = model_mem.exists(key) ? model_mem[key] : 32'h0;
                if (we[k]) begin
                    for (int b = 0; b < 4; b++) begin
                        if (be[k][b]) w[8*b +: 8] = wdata[k][8*b +: 8];
                    end
                    model_mem[key] = w;
                    pend.push_back('{k, cyc + cfg_lat(k), 32'h0});
                end else begin
                    pend.push_back('{k, cyc + cfg_lat(k), w});
                end
                run[k] = 0;
            end else begin
                run[k] = req[k] ? run[k] + 1 : 0;
            end
        end
        if (rst) pend.delete();
    endtask

    task automatic tick();
        @(negedge clk);
        model_step();
        @(posedge clk);
        cyc++;
        #1;
    endtask

    task automatic xfer(input int k, input logic w, input logic [31:0] a, input logic [3:0] b,
                        input logic [31:0] d, output int acc);
        int n;
        req[k] = 1'b1; we[k] = w; addr[k] = a; be[k] = b; wdata[k] = d;
        n   = 0;
        acc = -1;
        while (acc < 0 && n < 50) begin
            int c;
            c = cyc;
            tick();
            if (last_gnt[k]) acc = c;
            n++;
        end
        chk("xfer_granted", k, {31'h0, acc >= 0}, 32'h1);
    endtask

    task automatic idle(input int k);
        req[k] = 1'b0; we[k] = 1'b0;
    endtask

    task automatic pop_seen(input int k, output int c, output logic [31:0] d);
        int qi;
        qi = -1;
        for (int j = 0; j < seen.size(); j++) begin
            if (qi < 0 && seen[j].inst == k) qi = j;
        end
        c = -1;
        d = 32'h0;
        if (qi >= 0) begin
            c = seen[qi].cyc;
            d = seen[qi].data;
            seen.delete(qi);
        end
    endtask

    initial begin
        int          c0, c1, s, oc;
        logic [31:0] od;
        logic [31:0] be_exp [5];

        rst = 1'b1; req = '0; we = '0; addr = '0; be = '0; wdata = '0;
        cyc = 0; checks = 0; failures = 0; last_gnt = '0;
        for (int k = 0; k < N; k++) run[k] = 0;
        @(posedge clk);
        #1;
        req[0] = 1'b1;
        tick();
        tick();
        chk("reset_gnt_low", 0, {31'h0, last_gnt[0]}, 32'h0);
        req[0] = 1'b0;
        rst    = 1'b0;
        tick();

        // Basic write then read, same-cycle grant, one-cycle response.
        s = cyc;
        xfer(0, 1'b1, 32'h10, 4'hF, 32'hDEADBEEF, c0);
        xfer(0, 1'b0, 32'h10, 4'hF, 32'h0, c1);
        idle(0); tick(); tick();
        chk("same_cycle_gnt", 0, 32'(c0), 32'(s));
        chk("b2b_accept", 0, 32'(c1), 32'(c0 + 1));
        pop_seen(0, oc, od);
        chk("wr_resp_cyc", 0, 32'(oc), 32'(c0 + 1));
        chk("wr_resp_data", 0, od, 32'h0);
        pop_seen(0, oc, od);
        chk("rd_resp_cyc", 0, 32'(oc), 32'(c1 + 1));
        chk("rd_resp_data", 0, od, 32'hDEADBEEF);

        // Byte lanes, including a be=0 write that still answers.
        xfer(0, 1'b1, 32'h20, 4'hF, 32'h11223344, c0);
        xfer(0, 1'b1, 32'h20, 4'h5, 32'hAABBCCDD, c0);
        xfer(0, 1'b0, 32'h20, 4'h0, 32'h0, c0);
        xfer(0, 1'b1, 32'h20, 4'h0, 32'hFFFFFFFF, c0);
        xfer(0, 1'b0, 32'h20, 4'hF, 32'h0, c0);
        idle(0); tick(); tick();
        be_exp[0] = 32'h0; be_exp[1] = 32'h0; be_exp[2] = 32'h11BB33DD;
        be_exp[3] = 32'h0; be_exp[4] = 32'h11BB33DD;
        for (int i = 0; i < 5; i++) begin
            pop_seen(0, oc, od);
            chk("be_resp_present", 0, {31'h0, oc >= 0}, 32'h1);
            chk("be_resp_data", 0, od, be_exp[i]);
        end

        // Aliasing with read-after-write on the next cycle.
        xfer(0, 1'b1, 32'h40, 4'hF, 32'h5A5A5A5A, c0);
        xfer(0, 1'b0, 32'h00, 4'hF, 32'h0, c1);
        idle(0); tick(); tick();
        pop_seen(0, oc, od);
        chk("alias_wr_data", 0, od, 32'h0);
        pop_seen(0, oc, od);
        chk("alias_raw_data", 0, od, 32'h5A5A5A5A);

        // Grant wait states: grant in cycle 3, then every 4 cycles.
        s = cyc;
        xfer(1, 1'b1, 32'h0, 4'hF, 32'h12345678, c0);
        xfer(1, 1'b0, 32'h0, 4'hF, 32'h0, c1);
        idle(1); tick(); tick();
        chk("wait_first_gnt", 1, 32'(c0), 32'(s + 3));
        chk("wait_spacing", 1, 32'(c1), 32'(c0 + 4));
        pop_seen(1, oc, od);
        chk("wait_wr_cyc", 1, 32'(oc), 32'(c0 + 1));
        pop_seen(1, oc, od);
        chk("wait_rd_data", 1, od, 32'h12345678);

        // Request dropped in cycle 2: no grant, count restarts.
        req[1] = 1'b1; we[1] = 1'b0; addr[1] = 32'h0;
        tick();
        chk("drop_no_gnt0", 1, {31'h0, last_gnt[1]}, 32'h0);
        tick();
        chk("drop_no_gnt1", 1, {31'h0, last_gnt[1]}, 32'h0);
        idle(1);
        tick();
        s = cyc;
        xfer(1, 1'b0, 32'h0, 4'hF, 32'h0, c0);
        idle(1); tick(); tick();
        chk("restart_gnt", 1, 32'(c0), 32'(s + 3));
        pop_seen(1, oc, od);
        chk("restart_rd_data", 1, od, 32'h12345678);

        // Four in-flight reads with latency 4.
        for (int i = 0; i < 4; i++) xfer(2, 1'b1, 32'(4 * i), 4'hF, 32'(i + 1), c0);
        s = -1;
        for (int i = 0; i < 4; i++) begin
            xfer(2, 1'b0, 32'(4 * i), 4'hF, 32'h0, c1);
            if (i == 0) s = c1;
        end
        idle(2);
        repeat (6) tick();
        for (int i = 0; i < 4; i++) begin
            pop_seen(2, oc, od);
            chk("pipe_wr_data", 2, od, 32'h0);
        end
        for (int i = 0; i < 4; i++) begin
            pop_seen(2, oc, od);
            chk("pipe_rd_cyc", 2, 32'(oc), 32'(s + 4 + i));
            chk("pipe_rd_data", 2, od, 32'(i + 1));
        end

        // Reset with two reads in flight.
        xfer(3, 1'b1, 32'h8, 4'hF, 32'hCAFEF00D, c0);
        idle(3);
        repeat (4) tick();
        pop_seen(3, oc, od);
        chk("rst_pre_wr_cyc", 3, 32'(oc), 32'(c0 + 3));
        xfer(3, 1'b0, 32'h8, 4'hF, 32'h0, c0);
        xfer(3, 1'b0, 32'h8, 4'hF, 32'h0, c1);
        rst = 1'b1;
        tick();
        chk("rst_gnt_low", 3, {31'h0, last_gnt[3]}, 32'h0);
        rst = 1'b0;
        idle(3);
        repeat (6) tick();
        pop_seen(3, oc, od);
        chk("rst_discarded", 3, 32'(oc), 32'hFFFFFFFF);
        xfer(3, 1'b0, 32'h8, 4'hF, 32'h0, c0);
        idle(3);
        repeat (4) tick();
        pop_seen(3, oc, od);
        chk("rst_persist_cyc", 3, 32'(oc), 32'(c0 + 3));
        chk("rst_persist_data", 3, od, 32'hCAFEF00D);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
